apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master_if.sv | 39 +++
 rtl/apb_master.sv | 158 +++++++++++++++
 tb/tb_apb_master.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// Command/response and APB requester signal bundle for apb_master.
// The master modport is the design side; slave is the command source plus APB completer.
interface apb_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pstrb, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pstrb, pwdata
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: one command becomes one SETUP/ACCESS transfer and one response pulse.
// Define APB_MASTER_TIMEOUT_EN to build the ACCESS-phase watchdog (limit set by TIMEOUT_CYCLES).
module apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         preset,
    apb_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [11:0] paddr_q, paddr_d;
    logic [3:0]  pstrb_q, pstrb_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic             timeout_hit;

    // Counter holds the number of ACCESS cycles already spent waiting.
    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));
`endif

    always_ff @(posedge clk) begin
        if (preset) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pstrb_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q    <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pstrb_q       <= pstrb_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pstrb_d       = pstrb_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d    = '0;
        rsp_timeout_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = bus.cmd_write;
                    paddr_d   = bus.cmd_addr;
                    pwdata_d  = bus.cmd_write ? bus.cmd_wdata : 32'h0;
                    pstrb_d   = bus.cmd_write ? bus.cmd_strb : 4'h0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // Completion wins over the watchdog in the terminal-count cycle.
                if (bus.pready) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.pslverr;
                    rsp_rdata_d = pwrite_q ? 32'h0 : bus.prdata;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        // Never ready in the response cycle, which forces an idle bus cycle between transfers.
        cmd_ready_d = (state_d == IDLE) && !rsp_valid_d;
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: vector table plus hand sequences, responses checked by a scoreboard.
// Timeout behaviour is checked in whichever form APB_MASTER_TIMEOUT_EN selects.
module tb_apb_master;

    typedef struct {
        logic        write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waitCycles;
        logic [31:0] prdata;
        logic        slverr;
        logic        errEarly;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    logic clk = 1'b0;
    logic preset;

    int testsRun = 0;
    int testsFailed = 0;

    rsp_t expQ[$];

    int          compWait = 0;
    logic [31:0] compRdata = 32'h0;
    logic        compErr = 1'b0;
    logic        compErrEarly = 1'b0;
    int          accessCnt = 0;

    vec_t vecs[7];

    apb_master_if bus();

    apb_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk    (clk),
        .preset (preset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Completer model: answers after compWait ACCESS cycles, junk data and optional early pslverr before that.
    always @(negedge clk) begin
        if (bus.psel === 1'b1 && bus.penable === 1'b1) begin
            bus.pready  = (accessCnt == compWait);
            bus.prdata  = (accessCnt == compWait) ? compRdata : 32'hBAD0_BAD0;
            bus.pslverr = (accessCnt == compWait) ? compErr : compErrEarly;
            accessCnt++;
        end else begin
            bus.pready  = 1'b0;
            bus.prdata  = 32'hBAD0_BAD0;
            bus.pslverr = 1'b0;
            accessCnt   = 0;
        end
    end

    // Scoreboard: every response pulse must match the oldest expected entry.
    always @(negedge clk) begin
        rsp_t e;
        if (bus.rsp_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRsp", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("rspRdata", bus.rsp_rdata, e.rdata);
                checkOutput("rspErr", 32'(bus.rsp_err), 32'(e.err));
                checkOutput("rspTimeout", 32'(bus.rsp_timeout), 32'(e.tmo));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalWatchdog: simulation time limit reached");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic setCompleter(input int w, input logic [31:0] rd, input logic err, input logic early);
        compWait     = w;
        compRdata    = rd;
        compErr      = err;
        compErrEarly = early;
    endtask

    task automatic waitReady();
        int guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (bus.cmd_ready !== 1'b1) checkOutput("cmdReadyWait", 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic driveCmd(input logic wr, input logic [11:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_strb  = strb;
    endtask

    // One full transfer with cycle-exact checks; cmd_* scrambled after accept.
    task automatic applyStimulus(input vec_t v);
        int penCycles = 0;
        logic [31:0] expWdata;
        logic [3:0]  expStrb;
        expWdata = v.write ? v.wdata : 32'h0;
        expStrb  = v.write ? v.strb : 4'h0;
        waitReady();
        setCompleter(v.waitCycles, v.prdata, v.slverr, v.errEarly);
        driveCmd(v.write, v.addr, v.wdata, v.strb);
        expQ.push_back('{v.expRdata, v.expErr, 1'b0});
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~v.write;
        bus.cmd_addr  = ~v.addr;
        bus.cmd_wdata = ~v.wdata;
        bus.cmd_strb  = ~v.strb;
        @(negedge clk);
        checkOutput("setupPsel", 32'(bus.psel), 32'd1);
        checkOutput("setupPenable", 32'(bus.penable), 32'd0);
        checkOutput("setupPaddr", 32'(bus.paddr), 32'(v.addr));
        checkOutput("setupPwrite", 32'(bus.pwrite), 32'(v.write));
        checkOutput("setupPwdata", bus.pwdata, expWdata);
        checkOutput("setupPstrb", 32'(bus.pstrb), 32'(expStrb));
        checkOutput("setupCmdReady", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        while (bus.psel === 1'b1 && bus.penable === 1'b1 && penCycles < 200) begin
            penCycles++;
            checkOutput("accessPaddr", 32'(bus.paddr), 32'(v.addr));
            checkOutput("accessPwdata", bus.pwdata, expWdata);
            checkOutput("accessPstrb", 32'(bus.pstrb), 32'(expStrb));
            checkOutput("accessPwrite", 32'(bus.pwrite), 32'(v.write));
            @(negedge clk);
        end
        checkOutput("penableCycles", 32'(penCycles), 32'(v.waitCycles + 1));
        checkOutput("rspPsel", 32'(bus.psel), 32'd0);
        checkOutput("rspValid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("rspCmdReady", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        checkOutput("postRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("postRspReady", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        int penCycles;
        vec_t v;

        //        write addr     wdata         strb  wait prdata        slverr early expRdata      expErr
        vecs[0] = '{1'b1, 12'h010, 32'hA5A5_1234, 4'hF, 0, 32'h5555_5555, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 12'h004, 32'h1111_1111, 4'hF, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b0, 12'h008, 32'h2222_2222, 4'h3, 2, 32'hCAFE_F00D, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1};
        vecs[3] = '{1'b0, 12'h00C, 32'h3333_3333, 4'hC, 1, 32'h1357_9BDF, 1'b0, 1'b1, 32'h1357_9BDF, 1'b0};
        vecs[4] = '{1'b1, 12'hFFC, 32'hFFFF_FFFF, 4'h5, 0, 32'h7777_7777, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[5] = '{1'b0, 12'h000, 32'h4444_4444, 4'hF, 0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[6] = '{1'b1, 12'h123, 32'h89AB_CDEF, 4'h0, 5, 32'h6666_6666, 1'b0, 1'b1, 32'h0000_0000, 1'b0};

        preset        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;

        repeat (3) @(negedge clk);
        checkOutput("resetPsel", 32'(bus.psel), 32'd0);
        checkOutput("resetPenable", 32'(bus.penable), 32'd0);
        checkOutput("resetCmdReady", 32'(bus.cmd_ready), 32'd0);
        checkOutput("resetRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("resetPaddr", 32'(bus.paddr), 32'd0);
        checkOutput("resetRspTimeout", 32'(bus.rsp_timeout), 32'd0);
        preset = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterReset", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Back-to-back: cmd_valid stays high across two commands.
        waitReady();
        setCompleter(0, 32'h0F0F_0F0F, 1'b0, 1'b0);
        driveCmd(1'b1, 12'h020, 32'h1111_2222, 4'h3);
        expQ.push_back('{32'h0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        driveCmd(1'b0, 12'h024, 32'h9999_9999, 4'hF);
        expQ.push_back('{32'h0F0F_0F0F, 1'b0, 1'b0});
        @(negedge clk);
        checkOutput("b2bSetupA", 32'(bus.psel), 32'd1);
        checkOutput("b2bAddrA", 32'(bus.paddr), 32'h020);
        checkOutput("b2bReadyA", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        checkOutput("b2bAccessA", 32'(bus.penable), 32'd1);
        @(negedge clk);
        checkOutput("b2bRspA", 32'(bus.rsp_valid), 32'd1);
        checkOutput("b2bRspReady", 32'(bus.cmd_ready), 32'd0);
        checkOutput("b2bRspPsel", 32'(bus.psel), 32'd0);
        @(negedge clk);
        checkOutput("b2bGapPsel", 32'(bus.psel), 32'd0);
        checkOutput("b2bGapReady", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2bSetupB", 32'(bus.psel), 32'd1);
        checkOutput("b2bAddrB", 32'(bus.paddr), 32'h024);
        checkOutput("b2bWriteB", 32'(bus.pwrite), 32'd0);
        @(negedge clk);
        checkOutput("b2bAccessB", 32'(bus.penable), 32'd1);
        @(negedge clk);
        checkOutput("b2bRspB", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);

        // Reset during ACCESS drops the transfer silently.
        waitReady();
        setCompleter(10, 32'h0, 1'b0, 1'b0);
        driveCmd(1'b1, 12'h7F0, 32'h600D_F00D, 4'hA);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midAccessPenable", 32'(bus.penable), 32'd1);
        preset = 1'b1;
        @(negedge clk);
        checkOutput("rstPsel", 32'(bus.psel), 32'd0);
        checkOutput("rstPenable", 32'(bus.penable), 32'd0);
        checkOutput("rstPwrite", 32'(bus.pwrite), 32'd0);
        checkOutput("rstPaddr", 32'(bus.paddr), 32'd0);
        checkOutput("rstPstrb", 32'(bus.pstrb), 32'd0);
        checkOutput("rstPwdata", bus.pwdata, 32'd0);
        checkOutput("rstRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rstRspRdata", bus.rsp_rdata, 32'd0);
        checkOutput("rstRspErr", 32'(bus.rsp_err), 32'd0);
        checkOutput("rstCmdReady", 32'(bus.cmd_ready), 32'd0);
        preset = 1'b0;
        @(negedge clk);
        checkOutput("rstReleaseReady", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rstReleasePsel", 32'(bus.psel), 32'd0);
        repeat (3) @(negedge clk);

        // Completer that never answers.
        waitReady();
        setCompleter(1000000, 32'h0, 1'b0, 1'b0);
        driveCmd(1'b0, 12'h040, 32'h0, 4'h0);
`ifdef APB_MASTER_TIMEOUT_EN
        expQ.push_back('{32'h0, 1'b1, 1'b1});
`endif
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
`ifdef APB_MASTER_TIMEOUT_EN
        penCycles = 0;
        while (bus.psel === 1'b1 && bus.penable === 1'b1 && penCycles < 100) begin
            penCycles++;
            @(negedge clk);
        end
        checkOutput("timeoutPenCycles", 32'(penCycles), 32'd17);
        checkOutput("timeoutRspValid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("timeoutPsel", 32'(bus.psel), 32'd0);
        @(negedge clk);
        checkOutput("timeoutReadyAfter", 32'(bus.cmd_ready), 32'd1);
        // pready in the terminal-count cycle completes normally.
        v = '{1'b0, 12'h044, 32'h0, 4'h0, 16, 32'hA1B2_C3D4, 1'b0, 1'b0, 32'hA1B2_C3D4, 1'b0};
        applyStimulus(v);
`else
        repeat (100) begin
            if (bus.rsp_timeout !== 1'b0) checkOutput("stuckRspTimeout", 32'(bus.rsp_timeout), 32'd0);
            @(negedge clk);
        end
        checkOutput("stuckPsel", 32'(bus.psel), 32'd1);
        checkOutput("stuckPenable", 32'(bus.penable), 32'd1);
        checkOutput("stuckRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("stuckRspTimeout", 32'(bus.rsp_timeout), 32'd0);
        preset = 1'b1;
        @(negedge clk);
        preset = 1'b0;
        @(negedge clk);
        v = '{1'b0, 12'h048, 32'h0, 4'h0, 2, 32'h2468_ACE0, 1'b0, 1'b0, 32'h2468_ACE0, 1'b0};
        applyStimulus(v);
`endif

        repeat (3) @(negedge clk);
        checkOutput("pendingRsp", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
